// File: rtl/key_event_queue.sv
// key_event_queue: latches key pulses, pushes the lowest pending key into a show-ahead FIFO.
// Optional KEY_EVT_TIMESTAMP_EN adds a free-running counter and per-event timestamps on EVT_TS.
module key_event_queue #(
  parameter int N_KEYS = 4,
  parameter int DEPTH = 8,
`ifdef KEY_EVT_TIMESTAMP_EN
  parameter int TS_W = 16,
`endif
  parameter int CODE_W = $clog2(N_KEYS)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [N_KEYS-1:0]      PULSE,
  output logic                   EVT_VALID,
  input  logic                   EVT_READY,
  output logic [CODE_W-1:0]      EVT_CODE,
`ifdef KEY_EVT_TIMESTAMP_EN
  output logic [TS_W-1:0]        EVT_TS,
`endif
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVERFLOW,
  input  logic                   CLR_OVF
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [N_KEYS-1:0] pend, clr;
  logic [AW-1:0] wptr, rptr;
  logic [CODE_W-1:0] code_mem [DEPTH];
  logic [CODE_W-1:0] sel;
  logic pop, push, loss;
  // Storage is not reset; the head is masked so idle outputs read as zero.
  assign EVT_VALID = COUNT != '0;
  assign EVT_CODE = EVT_VALID ? code_mem[rptr] : '0;
  assign pop = EVT_VALID & EVT_READY;
  assign push = (|pend) & ((COUNT != FULL) | pop);
  always_comb begin
    sel = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) sel = pend[i] ? CODE_W'(i) : sel;
  end
  assign clr = push ? N_KEYS'(1) << sel : '0;
  assign loss = |(PULSE & pend & ~clr);
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      pend <= '0;
      wptr <= '0;
      rptr <= '0;
      COUNT <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | PULSE;
      OVERFLOW <= loss | (OVERFLOW & ~CLR_OVF);
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      if (push != pop) COUNT <= push ? COUNT + CW'(1) : COUNT - CW'(1);
    end
  always_ff @(posedge CLK)
    if (push) code_mem[wptr] <= sel;
`ifdef KEY_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] stamp [N_KEYS];
  logic [TS_W-1:0] ts_mem [DEPTH];
  assign EVT_TS = EVT_VALID ? ts_mem[rptr] : '0;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) ts_cnt <= '0;
    else ts_cnt <= ts_cnt + TS_W'(1);
  // A dropped press must not overwrite the stamp of the press still pending.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_KEYS; i++) if (PULSE[i] & (~pend[i] | clr[i])) stamp[i] <= ts_cnt;
    if (push) ts_mem[wptr] <= stamp[sel];
  end
`endif
endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue: directed and random stimulus against a queue-based model of key_event_queue.
module tb_key_event_queue;
  localparam int N = 4;
  localparam int D = 8;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic EVT_READY = 1'b0;
  logic CLR_OVF = 1'b0;
  logic [N-1:0] PULSE = '0;
  logic EVT_VALID, OVERFLOW;
  logic [1:0] EVT_CODE;
  logic [3:0] COUNT;
`ifdef KEY_EVT_TIMESTAMP_EN
  logic [15:0] EVT_TS;
`endif
  int vectors = 0;
  int miscompares = 0;
  int mq[$];
  logic [15:0] tq[$];
  logic [N-1:0] m_pend = '0;
  logic [15:0] m_stamp [N];
  logic m_ovf = 1'b0;
  logic [15:0] m_ts = '0;

  key_event_queue dut (
    .CLK(CLK),
    .RESET(RESET),
    .PULSE(PULSE),
    .EVT_VALID(EVT_VALID),
    .EVT_READY(EVT_READY),
    .EVT_CODE(EVT_CODE),
`ifdef KEY_EVT_TIMESTAMP_EN
    .EVT_TS(EVT_TS),
`endif
    .COUNT(COUNT),
    .OVERFLOW(OVERFLOW),
    .CLR_OVF(CLR_OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    tq.delete();
    m_pend = '0;
    m_ovf = 1'b0;
    m_ts = '0;
  endfunction

  function automatic void model_step();
    int k;
    bit loss;
    k = -1;
    loss = 1'b0;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i]) k = i;
    if (mq.size() > 0 && EVT_READY) begin
      void'(mq.pop_front());
      void'(tq.pop_front());
    end
    if (k >= 0 && mq.size() < D) begin
      mq.push_back(k);
      tq.push_back(m_stamp[k]);
      m_pend[k] = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (PULSE[i]) begin
        if (m_pend[i]) loss = 1'b1;
        else begin
          m_pend[i] = 1'b1;
          m_stamp[i] = m_ts;
        end
      end
    m_ovf = loss || (m_ovf && !CLR_OVF);
    m_ts++;
  endfunction

  always @(posedge RESET) model_reset();
  always @(posedge CLK) if (RESET) model_reset(); else model_step();

  always @(negedge CLK) begin
    chk("valid", EVT_VALID, mq.size() > 0);
    chk("count", COUNT, mq.size());
    chk("overflow", OVERFLOW, m_ovf);
    if (mq.size() > 0) begin
      chk("code", EVT_CODE, mq[0]);
`ifdef KEY_EVT_TIMESTAMP_EN
      chk("ts", EVT_TS, tq[0]);
`endif
    end
  end

  task automatic apply(input logic [N-1:0] p, input logic r, input logic c);
    PULSE = p;
    EVT_READY = r;
    CLR_OVF = c;
  endtask

  task automatic drive(input logic [N-1:0] p, input logic r, input logic c);
    @(negedge CLK);
    apply(p, r, c);
  endtask

  task automatic after_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ts(input logic [15:0] v);
    int k;
    k = 0;
    while (m_ts != v && k < 70000) begin
      @(negedge CLK);
      k++;
    end
    vectors++;
    if (m_ts != v) begin
      miscompares++;
      $display("FAIL ts_wait: counter %0h, wanted %0h", m_ts, v);
    end
  endtask

  initial begin
    int rp;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    chk("rst_valid", EVT_VALID, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_ovf", OVERFLOW, 0);
    chk("rst_code", EVT_CODE, 0);
    drive(4'b0100, 0, 0);
    drive(0, 0, 0);
    chk("lat_pend_only", EVT_VALID, 0);
    after_edge();
    chk("lat_valid", EVT_VALID, 1);
    chk("lat_code", EVT_CODE, 2);
    chk("lat_count", COUNT, 1);
    drive(0, 1, 0);
    after_edge();
    chk("pop_valid", EVT_VALID, 0);
    chk("pop_count", COUNT, 0);
    drive(4'b1011, 1, 0);
    drive(0, 1, 0);
    after_edge();
    chk("sim_code0", EVT_CODE, 0);
    after_edge();
    chk("sim_code1", EVT_CODE, 1);
    after_edge();
    chk("sim_code3", EVT_CODE, 3);
    after_edge();
    chk("sim_empty", EVT_VALID, 0);
    chk("sim_ovf", OVERFLOW, 0);
    for (int i = 0; i < 9; i++) drive(4'(1) << (i % 4), 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("full_count", COUNT, 8);
    chk("full_head", EVT_CODE, 0);
    drive(0, 1, 0);
    after_edge();
    chk("full_refill", COUNT, 8);
    chk("full_next", EVT_CODE, 1);
    chk("full_ovf", OVERFLOW, 0);
    drive(4'b0010, 0, 0);
    drive(4'b0010, 0, 0);
    drive(4'b0010, 0, 0);
    drive(0, 0, 0);
    chk("loss_ovf", OVERFLOW, 1);
    drive(0, 0, 1);
    after_edge();
    chk("clr_ovf", OVERFLOW, 0);
    drive(4'b0010, 0, 1);
    drive(0, 0, 0);
    chk("clr_vs_loss", OVERFLOW, 1);
    drive(0, 0, 1);
    repeat (12) drive(0, 1, 0);
    drive(0, 0, 0);
    drive(4'b0001, 0, 0);
    drive(4'b0010, 0, 0);
    drive(4'b0100, 0, 0);
    drive(4'b1000, 0, 0);
    drive(4'b0001, 0, 0);
    drive(4'b0100, 0, 0);
    after_edge();
    chk("pre_rst_count", COUNT, 5);
    #1 RESET = 1'b1;
    #1;
    chk("arst_valid", EVT_VALID, 0);
    chk("arst_count", COUNT, 0);
    chk("arst_ovf", OVERFLOW, 0);
    chk("arst_code", EVT_CODE, 0);
    drive(4'b1111, 0, 0);
    drive(4'b1111, 1, 0);
    drive(0, 0, 0);
    RESET = 1'b0;
    drive(4'b0010, 0, 0);
    drive(0, 0, 0);
    chk("post_rst_pend", EVT_VALID, 0);
    after_edge();
    chk("post_rst_valid", EVT_VALID, 1);
    chk("post_rst_code", EVT_CODE, 1);
    chk("post_rst_count", COUNT, 1);
    drive(0, 1, 0);
    drive(0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      rp = (c / 250) % 3 == 0 ? 15 : ((c / 250) % 3 == 1 ? 60 : 95);
      drive($urandom_range(0, 2) == 0 ? N'($urandom) : '0, $urandom_range(0, 99) < rp,
            $urandom_range(0, 15) == 0);
      if (c == 1777) begin
        #3 RESET = 1'b1;
        #10 RESET = 1'b0;
      end
    end
`ifdef KEY_EVT_TIMESTAMP_EN
    drive(0, 0, 0);
    RESET = 1'b1;
    drive(0, 0, 0);
    drive(0, 0, 0);
    RESET = 1'b0;
    wait_ts(16'd10);
    apply(4'b0001, 0, 0);
    drive(0, 0, 0);
    drive(4'b1000, 0, 0);
    repeat (3) drive(0, 0, 0);
    chk("ts_a_code", EVT_CODE, 0);
    chk("ts_a", EVT_TS, 16'd10);
    chk("ts_a_count", COUNT, 2);
    drive(0, 1, 0);
    after_edge();
    chk("ts_b_code", EVT_CODE, 3);
    chk("ts_b", EVT_TS, 16'd12);
    drive(0, 1, 0);
    drive(0, 0, 0);
    wait_ts(16'hFFFF);
    apply(4'b0100, 0, 0);
    drive(4'b0010, 0, 0);
    repeat (3) drive(0, 0, 0);
    chk("ts_max_code", EVT_CODE, 2);
    chk("ts_max", EVT_TS, 16'hFFFF);
    drive(0, 1, 0);
    after_edge();
    chk("ts_wrap_code", EVT_CODE, 1);
    chk("ts_wrap", EVT_TS, 16'h0000);
`endif
    drive(0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/key_event_queue.md
# key_event_queue

Collects the single-cycle key pulses produced by the per-button debounce/one-shot stages and queues them as coded events for the processor core. Each button's pulse is latched, arbitrated, and pushed into a small show-ahead FIFO read with a valid/ready handshake. Lost presses are reported through a sticky overflow flag. The block sits directly downstream of the pulse generators and upstream of the core's input port.

## Interface
Parameters:
- N_KEYS, 4, number of pulse inputs (2..16)
- DEPTH, 8, FIFO entries (power of two, 2..64)
- CODE_W, $clog2(N_KEYS), event code width (derived, not overridden)
- TS_W, 16, timestamp width (used only with KEY_EVT_TIMESTAMP_EN)

Ports:
- CLK  in  1  single system clock; all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- PULSE  in  N_KEYS  one-cycle key pulses from the pulse generators, bit i = key i
- EVT_VALID  out  1  FIFO head holds an event
- EVT_READY  in  1  consumer accepts head this cycle
- EVT_CODE  out  CODE_W  key index of head event
- EVT_TS  out  TS_W  timestamp of head event (only with KEY_EVT_TIMESTAMP_EN)
- COUNT  out  $clog2(DEPTH)+1  entries currently stored
- OVERFLOW  out  1  sticky: at least one press lost
- CLR_OVF  in  1  clears OVERFLOW

## Operation
- Pending stage: one PEND bit per key. PULSE[i]=1 sets PEND[i] at the next edge.
- Arbiter: each cycle, if any PEND bit is set and a push is possible, the lowest-index pending key is pushed and its PEND bit is cleared at the same edge.
- Push possible when COUNT<DEPTH, or COUNT==DEPTH with a pop in the same cycle.
- Pop occurs when EVT_VALID & EVT_READY. EVT_READY with EVT_VALID=0 has no effect.
- FIFO is show-ahead: EVT_CODE/EVT_TS are valid whenever EVT_VALID=1 and hold steady until popped.
- Full FIFO: events wait in PEND; nothing is lost.
- Loss rule: PULSE[i]=1 while PEND[i]=1 and PEND[i] is not being cleared that cycle drops that press and sets OVERFLOW. PULSE[i] in the same cycle PEND[i] is pushed re-sets PEND[i] and is not a loss.
- CLR_OVF clears OVERFLOW at the next edge. A loss in the same cycle wins, so OVERFLOW stays 1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. COUNT is updated +1 on push only, -1 on pop only, unchanged on both.
- Reset values: PEND=0, pointers=0, COUNT=0, EVT_VALID=0, OVERFLOW=0, EVT_CODE=0, EVT_TS=0, timestamp counter=0.
- Reset mid-operation: all queued and pending events are discarded immediately (asynchronous). Pulses during RESET are ignored.

## Timing
- Latency with an empty FIFO and no contention: PULSE high in cycle t, PEND set at edge t+1, pushed at edge t+2, EVT_VALID=1 from edge t+2.
- N simultaneous pulses drain into the FIFO one per cycle in ascending key order.
- Throughput: one push and one pop per cycle sustained.
- Outputs are registered or derived from registers only. There is no combinational path from PULSE or EVT_READY to any output.

## Configuration
- KEY_EVT_TIMESTAMP_EN defined:
  - A free-running TS_W-bit counter (reset 0, increments every cycle, wraps) is added.
  - When PEND[i] is set, the counter value is captured into a per-key stamp register.
  - The stamp travels with the event and appears on EVT_TS.
- KEY_EVT_TIMESTAMP_EN undefined: the counter and stamp storage are absent, the EVT_TS port does not exist, and all other behaviour is identical.

## Test plan
- Single press: PULSE=4'b0100 for 1 cycle at t, EVT_READY=0 -> EVT_VALID=1 and EVT_CODE=2 from edge t+2, COUNT=1. Raise EVT_READY -> EVT_VALID=0 and COUNT=0 the next cycle.
- Simultaneous: PULSE=4'b1011 for 1 cycle, EVT_READY=1 -> codes pop in order 0, 1, 3 on consecutive cycles. OVERFLOW stays 0.
- Full: DEPTH=8, EVT_READY=0, 9 separate presses across keys 0..3 -> COUNT=8, the 9th is held in PEND. One pop -> the 9th is pushed and COUNT returns to 8. OVERFLOW stays 0.
- Loss: FIFO full, PULSE[1] twice while PEND[1]=1 -> OVERFLOW=1. CLR_OVF for 1 cycle -> OVERFLOW=0. CLR_OVF coincident with another loss -> OVERFLOW remains 1.
- Reset mid-operation: COUNT=5 with PEND nonzero, assert RESET between edges -> all outputs go to reset values immediately. After release, a single press is delivered with the 2-cycle latency.
- Timestamp (macro defined): press key 0 at counter=10 and key 3 at counter=12 -> EVT_TS=10 then 12. Then a press at counter=0xFFFF -> EVT_TS=0xFFFF, and the next cycle's press gives EVT_TS=0x0000 (wrap).
